// File: rtl/temporal_fold_scheduler.sv
// Feeds one folded sample at a time into temporal_encoder, walking folds high to low.
// On the last N-gram element each fold waits for the AM side to take the previous output.
module temporal_fold_scheduler #(
   parameter int NUM_FOLDS       = 10,
   parameter int NUM_FOLDS_WIDTH = 4,
   parameter int NGRAM_SIZE      = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_valid,
   output logic                       sample_done,
   output logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
   output logic                       enc_valid,
   input  logic                       enc_ready,
   output logic [1:0]                 classification_counter,
   output logic                       send_to_am,
   input  logic                       out_fire,
   input  logic                       flush,
   output logic                       ngram_done,
   output logic                       enc_clear,
   output logic                       busy
);

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_OUT, FINISH} state_t;

   localparam logic [NUM_FOLDS_WIDTH-1:0] FOLD_TOP = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
   localparam logic [NUM_FOLDS_WIDTH-1:0] FOLD_ONE = NUM_FOLDS_WIDTH'(1);
   localparam logic [1:0]                 CC_LAST  = 2'(NGRAM_SIZE - 1);

   state_t                     state, state_nxt;
   logic [NUM_FOLDS_WIDTH-1:0] fold_nxt;
   logic [1:0]                 cc_nxt;
   logic                       done_nxt, ngram_nxt, clear_nxt;
   logic                       fire, fold_last;

   assign enc_valid  = (state == ISSUE);
   assign busy       = (state != IDLE);
   assign send_to_am = (classification_counter == CC_LAST);
   assign fire       = enc_valid && enc_ready;
   assign fold_last  = (fold_idx == '0);

   always_comb begin
      state_nxt = state;
      fold_nxt  = fold_idx;
      cc_nxt    = classification_counter;
      done_nxt  = 1'b0;
      ngram_nxt = 1'b0;
      clear_nxt = 1'b0;
      if (flush) begin
         // Abandon the N-gram; the pending sample is picked up again from the top fold.
         state_nxt = IDLE;
         fold_nxt  = FOLD_TOP;
         cc_nxt    = '0;
         clear_nxt = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (sample_valid) begin
                  state_nxt = LOAD;
                  fold_nxt  = FOLD_TOP;
               end
            end
            LOAD: state_nxt = ISSUE;
            ISSUE: begin
               if (fire) begin
                  if (send_to_am)     state_nxt = WAIT_OUT;
                  else if (fold_last) state_nxt = FINISH;
                  else                fold_nxt  = fold_idx - FOLD_ONE;
               end
            end
            WAIT_OUT: begin
               if (out_fire) begin
                  if (fold_last) begin
                     state_nxt = FINISH;
                  end else begin
                     fold_nxt  = fold_idx - FOLD_ONE;
                     state_nxt = ISSUE;
                  end
               end
            end
            FINISH: begin
               done_nxt  = 1'b1;
               ngram_nxt = send_to_am;
               cc_nxt    = send_to_am ? 2'd0 : classification_counter + 2'd1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Pulses are registered, so they land one cycle after FINISH together with the new counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                  <= IDLE;
         fold_idx               <= FOLD_TOP;
         classification_counter <= '0;
         sample_done            <= 1'b0;
         ngram_done             <= 1'b0;
         enc_clear              <= 1'b0;
      end else begin
         state                  <= state_nxt;
         fold_idx               <= fold_nxt;
         classification_counter <= cc_nxt;
         sample_done            <= done_nxt;
         ngram_done             <= ngram_nxt;
         enc_clear              <= clear_nxt;
      end
   end

endmodule

// File: tb/tb_temporal_fold_scheduler.sv
// Bench for temporal_fold_scheduler: directed steps plus randomized samples checked
// against a transaction-level model of fold order, N-gram position and pulse timing.
module tb_temporal_fold_scheduler;

   localparam int NF = 4;
   localparam int NG = 3;

   logic clk = 1'b0;
   logic rst, sample_valid, enc_ready, out_fire, flush;
   logic sample_done, enc_valid, send_to_am, ngram_done, enc_clear, busy;
   logic [1:0] fold_idx;
   logic [1:0] classification_counter;
   logic d10_sample_done, d10_enc_valid, d10_send_to_am, d10_ngram_done, d10_enc_clear, d10_busy;
   logic [3:0] d10_fold_idx;
   logic [1:0] d10_cc;

   int n_tests = 0;
   int n_fail  = 0;
   int m_cc    = 0;

   always #5 clk = ~clk;

   temporal_fold_scheduler #(.NUM_FOLDS(NF), .NUM_FOLDS_WIDTH(2), .NGRAM_SIZE(NG)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_done(sample_done),
      .fold_idx(fold_idx), .enc_valid(enc_valid), .enc_ready(enc_ready),
      .classification_counter(classification_counter), .send_to_am(send_to_am),
      .out_fire(out_fire), .flush(flush), .ngram_done(ngram_done),
      .enc_clear(enc_clear), .busy(busy)
   );

   temporal_fold_scheduler dut10 (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_done(d10_sample_done),
      .fold_idx(d10_fold_idx), .enc_valid(d10_enc_valid), .enc_ready(enc_ready),
      .classification_counter(d10_cc), .send_to_am(d10_send_to_am),
      .out_fire(out_fire), .flush(flush), .ngram_done(d10_ngram_done),
      .enc_clear(d10_enc_clear), .busy(d10_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One upstream sample from acceptance to sample_done (or to a flush).
   task automatic run_sample(input int rmode, input int long_fold, input int flush_fold,
                             input bit rand_dly, output bit flushed);
      int exp_fold, cyc, fires, dly;
      bit fin, done, fired, fl;
      fin = (m_cc == NG - 1);
      flushed = 0; done = 0; exp_fold = NF - 1; fires = 0; cyc = 0;
      sample_valid = 1; enc_ready = 0; out_fire = 0;
      chk("idle_busy", 32'(busy), 0);
      tick();
      chk("load_enc_valid", 32'(enc_valid), 0);
      chk("load_busy", 32'(busy), 1);
      chk("load_fold", 32'(fold_idx), NF - 1);
      chk("load_pulses_low", 32'({sample_done, ngram_done, enc_clear}), 0);
      while (!done && cyc < 300) begin
         chk("cc", 32'(classification_counter), 32'(m_cc));
         chk("send_to_am", 32'(send_to_am), 32'(fin));
         if (enc_valid) chk("fold_seq", 32'(fold_idx), 32'(exp_fold));
         case (rmode)
            0:       enc_ready = 1'b1;
            1:       enc_ready = (cyc % 3 == 2);
            default: enc_ready = 1'($urandom_range(0, 1));
         endcase
         out_fire = 1'($urandom_range(0, 1));
         fl = (flush_fold >= 0) && enc_valid && (int'(fold_idx) == flush_fold);
         flush = fl;
         fired = enc_valid && enc_ready && !fl;
         tick(); cyc++;
         flush = 0; out_fire = 0;
         if (fl) begin
            chk("flush_clear", 32'(enc_clear), 1);
            chk("flush_busy", 32'(busy), 0);
            chk("flush_cc", 32'(classification_counter), 0);
            chk("flush_fold", 32'(fold_idx), NF - 1);
            chk("flush_no_done", 32'({sample_done, ngram_done}), 0);
            m_cc = 0; flushed = 1; done = 1;
         end else begin
            if (fired) begin
               fires++;
               if (fin) begin
                  dly = (exp_fold == long_fold) ? 5 : (rand_dly ? int'($urandom_range(1, 4)) : 2);
                  for (int k = 0; k < dly; k++) begin
                     chk("wait_enc_valid", 32'(enc_valid), 0);
                     chk("wait_fold_hold", 32'(fold_idx), 32'(exp_fold));
                     chk("wait_busy", 32'(busy), 1);
                     enc_ready = 1'($urandom_range(0, 1));
                     out_fire = (k == dly - 1);
                     tick(); cyc++;
                  end
                  out_fire = 0;
               end
               exp_fold--;
            end
            if (sample_done) begin
               done = 1;
               chk("ngram_done", 32'(ngram_done), 32'(fin));
               chk("fire_count", 32'(fires), NF);
               if (rmode == 0 && !fin) chk("done_latency", 32'(cyc), NF + 2);
               m_cc = (m_cc + 1) % NG;
               chk("cc_after_done", 32'(classification_counter), 32'(m_cc));
               chk("busy_after_done", 32'(busy), 0);
               sample_valid = 0;
            end
         end
      end
      chk("sample_completed", 32'(done), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      bit fl;
      int fold_before;
      rst = 1; sample_valid = 0; enc_ready = 0; out_fire = 0; flush = 0;
      tick(); tick();
      rst = 0;
      // Reset values, then quiet idle on both the folded and default-size instances.
      for (int i = 0; i < 20; i++) begin
         chk("rst_fold4", 32'(fold_idx), NF - 1);
         chk("rst_cc4", 32'(classification_counter), 0);
         chk("rst_bits4", 32'({enc_valid, send_to_am, sample_done, ngram_done, enc_clear, busy}), 0);
         chk("rst_fold10", 32'(d10_fold_idx), 9);
         chk("rst_cc10", 32'(d10_cc), 0);
         chk("rst_bits10", 32'({d10_enc_valid, d10_send_to_am, d10_sample_done,
                                d10_ngram_done, d10_enc_clear, d10_busy}), 0);
         tick();
      end

      // Three back-to-back samples at full encoder rate; the third is the final element.
      for (int s = 0; s < 3; s++) run_sample(0, -1, -1, 0, fl);

      // Final-sample backpressure: fold 2 waits 5 cycles for the AM side.
      run_sample(2, -1, -1, 0, fl);
      run_sample(2, -1, -1, 0, fl);
      run_sample(0, 2, -1, 0, fl);

      // Encoder-rate stall: ready one cycle in three.
      for (int s = 0; s < 3; s++) run_sample(1, -1, -1, 0, fl);

      // Flush from idle brings the counter back to the N-gram start.
      flush = 1; tick(); flush = 0;
      chk("idle_flush_clear", 32'(enc_clear), 1);
      chk("idle_flush_cc", 32'(classification_counter), 0);
      chk("idle_flush_fold", 32'(fold_idx), NF - 1);
      m_cc = 0;
      tick();
      chk("idle_flush_clear_low", 32'(enc_clear), 0);

      // Flush mid-ISSUE on the second sample, then the pending sample restarts.
      run_sample(0, -1, -1, 0, fl);
      run_sample(0, -1, 1, 0, fl);
      chk("flush_taken", 32'(fl), 1);
      run_sample(0, -1, -1, 0, fl);

      // Stray out_fire while idle changes nothing.
      fold_before = int'(fold_idx);
      for (int i = 0; i < 5; i++) begin
         out_fire = 1; tick();
         chk("stray_busy", 32'(busy), 0);
         chk("stray_cc", 32'(classification_counter), 32'(m_cc));
         chk("stray_fold", 32'(fold_idx), 32'(fold_before));
      end
      out_fire = 0;

      // Randomized traffic with idle gaps and occasional flushes.
      for (int s = 0; s < 25; s++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            out_fire = 1'($urandom_range(0, 1));
            tick();
            chk("gap_busy", 32'(busy), 0);
         end
         out_fire = 0;
         run_sample($urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NF - 1)) : -1,
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NF - 1)) : -1, 1, fl);
         if (fl) run_sample($urandom_range(0, 2), -1, -1, 1, fl);
      end

      // rst and flush together mid-sample: reset wins and no encoder clear is issued.
      sample_valid = 1; enc_ready = 0;
      tick(); tick();
      rst = 1; flush = 1;
      tick();
      chk("rstflush_clear", 32'(enc_clear), 0);
      chk("rstflush_busy", 32'(busy), 0);
      chk("rstflush_cc", 32'(classification_counter), 0);
      chk("rstflush_fold", 32'(fold_idx), NF - 1);
      rst = 0; flush = 0; sample_valid = 0;
      tick();
      chk("post_rst_idle", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
